conv11_ctrl: RTL and testbench
==============================

CONV11_CTRL -- requirements
Module: conv11_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of output-channel groups per layer (>=1).
REQ-002 SHALL have parameter N_PIX, default 16, output beats per channel group (>=1).
REQ-003 SHALL have parameter CW, default 8, width of the ch_idx and pix_idx counters; CW must cover N_CH-1 and N_PIX-1.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port cfg_start, input, 1, single-cycle layer-start request.
REQ-007 SHALL have port abort, input, 1, level; cancels the layer in progress.
REQ-008 SHALL have port wload_req, output, 1, weight-load request for group ch_idx.
REQ-009 SHALL have port wload_ack, input, 1, single-cycle pulse: weights for the group are loaded.
REQ-010 SHALL have port dp_start, output, 1, enable level to the output stage datapath.
REQ-011 SHALL have port dp_beat, input, 1, pulse per accepted output beat (datapath done).
REQ-012 SHALL have port ch_idx, output, CW, current channel group.
REQ-013 SHALL have port pix_idx, output, CW, beats completed in the current group.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port layer_done, output, 1, single-cycle pulse at layer completion.
REQ-016 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-017 SHALL implement the states IDLE, LOAD_W, RUN and DONE; all outputs SHALL be registered.
REQ-018 In IDLE, cfg_start=1 SHALL, next cycle: enter LOAD_W; ch_idx=0; pix_idx=0; wload_req=1; err=0.
REQ-019 cfg_start in any state other than IDLE SHALL be ignored.
REQ-020 In LOAD_W, wload_ack=1 SHALL, next cycle: wload_req=0; dp_start=1; pix_idx=0; state RUN.
REQ-021 wload_ack outside LOAD_W SHALL be ignored and SHALL NOT set err.
REQ-022 In RUN, dp_beat=1 SHALL increment pix_idx by 1 when pix_idx<N_PIX-1.
REQ-023 In RUN, dp_beat=1 with pix_idx==N_PIX-1 SHALL, next cycle, set dp_start=0 and pix_idx=0.
REQ-024 Same event, ch_idx<N_CH-1: SHALL increment ch_idx, set wload_req=1, go to LOAD_W.
REQ-025 Same event, ch_idx==N_CH-1: SHALL go to DONE.
REQ-026 In DONE: layer_done=1 for exactly that cycle; next cycle IDLE with layer_done=0, ch_idx=0.
REQ-027 Minimum latency, cfg_start to layer_done: N_CH*(N_PIX+1)+2 cycles, with wload_ack and dp_beat asserted at the earliest opportunity.
REQ-028 dp_beat outside RUN SHALL set err=1; the beat SHALL NOT change counters or state.
REQ-029 err SHALL hold 1 until rst or an accepted cfg_start.
REQ-030 abort=1 in LOAD_W, RUN or DONE SHALL, next cycle: state IDLE; wload_req=0; dp_start=0; ch_idx=0; pix_idx=0; layer_done=0.
REQ-031 abort SHALL have priority over simultaneous wload_ack, dp_beat or cfg_start.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 No layer_done pulse SHALL be issued for an aborted layer.
REQ-034 dp_start and wload_req SHALL never be high in the same cycle.
REQ-035 With N_CH=1, the block SHALL pass through LOAD_W exactly once.
REQ-036 With N_PIX=1, each group SHALL complete on its first dp_beat.

Reset
REQ-037 While rst=1, outputs SHALL be: state IDLE; wload_req=0; dp_start=0; ch_idx=0; pix_idx=0; busy=0; layer_done=0; err=0.
REQ-038 rst asserted mid-layer SHALL abandon the layer with no layer_done.
REQ-039 After rst deasserts, the block SHALL accept a fresh cfg_start.

Verification
REQ-040 Nominal run (N_CH=2, N_PIX=4): cfg_start, wload_ack 1 cycle after wload_req, dp_beat every cycle in RUN -> two wload_req phases, ch_idx 0 then 1, 8 beats, layer_done exactly once, 12 cycles after cfg_start.
REQ-041 Stalled datapath: dp_beat gaps of 3 cycles -> pix_idx advances only on beats, dp_start stays 1 throughout RUN, layer_done after the 8th beat.
REQ-042 Abort at RUN, ch_idx=1, pix_idx=2 -> next cycle IDLE, all outputs zero, no layer_done; a following cfg_start completes normally.
REQ-043 Protocol error: dp_beat in IDLE -> err=1, counters unchanged; err holds through a second stray beat; err clears on the next cfg_start.
REQ-044 Simultaneous events: abort with the final dp_beat -> IDLE and no layer_done; cfg_start during RUN -> ignored, with ch_idx and pix_idx unchanged.
REQ-045 Async reset during LOAD_W with wload_req=1 -> wload_req drops without waiting for a clock edge, and all outputs take their REQ-037 values.

Source files
------------

// File: rtl/conv11_ctrl.sv
// conv11_ctrl -- sequencer for a 1x1 convolution layer.
// Walks N_CH output-channel groups; for each group it requests a weight load,
// then enables the datapath for N_PIX output beats. All outputs are registered.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   cfg_start   single-cycle layer-start request (accepted only in IDLE)
//   abort       level; cancels the layer in progress
//   wload_req   weight-load request for group ch_idx
//   wload_ack   pulse: weights for the group are loaded
//   dp_start    enable level to the output-stage datapath
//   dp_beat     pulse per accepted output beat
//   ch_idx      current channel group
//   pix_idx     beats completed in the current group
//   busy        high in every state except IDLE
//   layer_done  single-cycle pulse at layer completion
//   err         sticky protocol-error flag (dp_beat outside RUN)
module conv11_ctrl #(
   parameter int N_CH  = 8,
   parameter int N_PIX = 16,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_start,
   input  logic          abort,
   output logic          wload_req,
   input  logic          wload_ack,
   output logic          dp_start,
   input  logic          dp_beat,
   output logic [CW-1:0] ch_idx,
   output logic [CW-1:0] pix_idx,
   output logic          busy,
   output logic          layer_done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DONE} state_t;

   localparam logic [CW-1:0] CH_LAST  = CW'(N_CH - 1);
   localparam logic [CW-1:0] PIX_LAST = CW'(N_PIX - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t        state_q, state_d;
   logic          wload_req_q, wload_req_d;
   logic          dp_start_q, dp_start_d;
   logic [CW-1:0] ch_idx_q, ch_idx_d;
   logic [CW-1:0] pix_idx_q, pix_idx_d;
   logic          busy_q, busy_d;
   logic          layer_done_q, layer_done_d;
   logic          err_q, err_d;

   always_comb begin
      state_d      = state_q;
      wload_req_d  = wload_req_q;
      dp_start_d   = dp_start_q;
      ch_idx_d     = ch_idx_q;
      pix_idx_d    = pix_idx_q;
      layer_done_d = 1'b0;
      err_d        = err_q;

      // abort outranks every other input outside IDLE; a beat arriving with
      // it is discarded and does not count as a protocol error.
      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         wload_req_d = 1'b0;
         dp_start_d  = 1'b0;
         ch_idx_d    = '0;
         pix_idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  state_d     = LOAD_W;
                  ch_idx_d    = '0;
                  pix_idx_d   = '0;
                  wload_req_d = 1'b1;
                  dp_start_d  = 1'b0;
                  err_d       = 1'b0;
               end else if (dp_beat) begin
                  err_d = 1'b1;
               end
            end
            LOAD_W: begin
               if (dp_beat) err_d = 1'b1;
               if (wload_ack) begin
                  state_d     = RUN;
                  wload_req_d = 1'b0;
                  dp_start_d  = 1'b1;
                  pix_idx_d   = '0;
               end
            end
            RUN: begin
               if (dp_beat) begin
                  if (pix_idx_q == PIX_LAST) begin
                     dp_start_d = 1'b0;
                     pix_idx_d  = '0;
                     if (ch_idx_q == CH_LAST) begin
                        state_d      = DONE;
                        layer_done_d = 1'b1;
                     end else begin
                        state_d     = LOAD_W;
                        ch_idx_d    = ch_idx_q + ONE;
                        wload_req_d = 1'b1;
                     end
                  end else begin
                     pix_idx_d = pix_idx_q + ONE;
                  end
               end
            end
            DONE: begin
               state_d     = IDLE;
               ch_idx_d    = '0;
               pix_idx_d   = '0;
               wload_req_d = 1'b0;
               dp_start_d  = 1'b0;
               if (dp_beat) err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wload_req_q  <= 1'b0;
         dp_start_q   <= 1'b0;
         ch_idx_q     <= '0;
         pix_idx_q    <= '0;
         busy_q       <= 1'b0;
         layer_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wload_req_q  <= wload_req_d;
         dp_start_q   <= dp_start_d;
         ch_idx_q     <= ch_idx_d;
         pix_idx_q    <= pix_idx_d;
         busy_q       <= busy_d;
         layer_done_q <= layer_done_d;
         err_q        <= err_d;
      end
   end

   assign wload_req  = wload_req_q;
   assign dp_start   = dp_start_q;
   assign ch_idx     = ch_idx_q;
   assign pix_idx    = pix_idx_q;
   assign busy       = busy_q;
   assign layer_done = layer_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_conv11_ctrl.sv
// tb_conv11_ctrl -- directed vector bench for conv11_ctrl (N_CH=2, N_PIX=4)
// plus a second instance with N_CH=1, N_PIX=1 for the degenerate sizes.
module tb_conv11_ctrl;

   localparam int N_CH  = 2;
   localparam int N_PIX = 4;
   localparam int CW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_start = 1'b0, abort = 1'b0, wload_ack = 1'b0, dp_beat = 1'b0;

   logic          wload_req, dp_start, busy, layer_done, err;
   logic [CW-1:0] ch_idx, pix_idx;
   logic          wload_req_b, dp_start_b, busy_b, layer_done_b, err_b;
   logic [CW-1:0] ch_idx_b, pix_idx_b;

   conv11_ctrl #(.N_CH(N_CH), .N_PIX(N_PIX), .CW(CW)) u_dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .abort(abort),
      .wload_req(wload_req), .wload_ack(wload_ack), .dp_start(dp_start),
      .dp_beat(dp_beat), .ch_idx(ch_idx), .pix_idx(pix_idx), .busy(busy),
      .layer_done(layer_done), .err(err)
   );

   conv11_ctrl #(.N_CH(1), .N_PIX(1), .CW(CW)) u_dut_min (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .abort(abort),
      .wload_req(wload_req_b), .wload_ack(wload_ack), .dp_start(dp_start_b),
      .dp_beat(dp_beat), .ch_idx(ch_idx_b), .pix_idx(pix_idx_b), .busy(busy_b),
      .layer_done(layer_done_b), .err(err_b)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        cs, ab, ack, bt;
      logic [20:0] exp;   // {wload_req, dp_start, busy, layer_done, err, ch_idx, pix_idx}
   } vec_t;

   vec_t tbl[31];

   function automatic logic [20:0] pack(input logic wr, ds, b, ld, e, input int ch, pix);
      return {wr, ds, b, ld, e, CW'(ch), CW'(pix)};
   endfunction

   function automatic vec_t mk(input logic cs, ab, ack, bt, wr, ds, b, ld, e, input int ch, pix);
      vec_t v;
      v.cs = cs; v.ab = ab; v.ack = ack; v.bt = bt;
      v.exp = pack(wr, ds, b, ld, e, ch, pix);
      return v;
   endfunction

   function automatic logic [20:0] outs();
      return {wload_req, dp_start, busy, layer_done, err, ch_idx, pix_idx};
   endfunction

   function automatic logic [20:0] outs_b();
      return {wload_req_b, dp_start_b, busy_b, layer_done_b, err_b, ch_idx_b, pix_idx_b};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs for one clock period, then sample just after the rising edge.
   task automatic cyc(input logic cs, ab, ack, bt);
      @(negedge clk);
      cfg_start = cs; abort = ab; wload_ack = ack; dp_beat = bt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cycles, phases, beats, overlap, stall_bad;
      logic prev_wr;

      //                cs ab ak bt  wr ds b  ld e  ch pix
      // nominal layer, with a cfg_start ignored mid-RUN
      tbl[0]  = mk(1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 1);
      tbl[3]  = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2);
      tbl[4]  = mk(1, 0, 0, 0,  0, 1, 1, 0, 0, 0, 2);
      tbl[5]  = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 3);
      tbl[6]  = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 1, 0);
      tbl[7]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 1, 0);
      tbl[8]  = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 1);
      tbl[9]  = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 2);
      tbl[10] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 3);
      tbl[11] = mk(0, 0, 0, 1,  0, 0, 1, 1, 0, 1, 0);
      tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      // stray beats / acks in IDLE, abort in IDLE, err clear on start
      tbl[13] = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);
      tbl[15] = mk(0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0);
      tbl[16] = mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0);
      tbl[17] = mk(1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 1,  1, 0, 1, 0, 1, 0, 0);
      tbl[19] = mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0);
      // fresh layer, abort at ch_idx=1 pix_idx=2 together with cs/ack/beat
      tbl[20] = mk(1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
      tbl[21] = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 1);
      tbl[23] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2);
      tbl[24] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 3);
      tbl[25] = mk(0, 0, 0, 1,  1, 0, 1, 0, 0, 1, 0);
      tbl[26] = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 1, 0);
      tbl[27] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 1);
      tbl[28] = mk(0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 2);
      tbl[29] = mk(1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0);
      tbl[30] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 32'(outs()), 32'h0);
      chk("reset_state_min", 32'(outs_b()), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         cyc(tbl[i].cs, tbl[i].ab, tbl[i].ack, tbl[i].bt);
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      end

      // Earliest-opportunity layer. Periods counted inclusively from the one
      // driving cfg_start through the one showing layer_done = cycles + 2.
      cyc(1, 0, 0, 0);
      cycles = 0; phases = 1; beats = 0; overlap = 0; prev_wr = wload_req;
      for (int k = 0; k < 100 && !layer_done; k++) begin
         if (dp_start) beats++;
         cyc(0, 0, wload_req, dp_start);
         cycles++;
         if (wload_req && !prev_wr) phases++;
         if (wload_req && dp_start) overlap++;
         prev_wr = wload_req;
      end
      chk("latency", 32'(cycles + 2), 32'(N_CH * (N_PIX + 1) + 2));
      chk("wload_phases", 32'(phases), 32'(N_CH));
      chk("beats", 32'(beats), 32'(N_CH * N_PIX));
      chk("req_start_overlap", 32'(overlap), 32'd0);
      cyc(0, 0, 0, 0);
      chk("done_single_pulse", 32'(outs()), 32'h0);

      // Stalled datapath: three idle cycles before every beat.
      stall_bad = 0;
      cyc(1, 0, 0, 0);
      for (int g = 0; g < N_CH; g++) begin
         cyc(0, 0, 1, 0);
         for (int b = 0; b < N_PIX; b++) begin
            repeat (3) begin
               cyc(0, 0, 0, 0);
               if (pix_idx !== CW'(b) || dp_start !== 1'b1 || layer_done !== 1'b0) stall_bad++;
            end
            cyc(0, 0, 0, 1);
            if (b < N_PIX - 1) chk("stall_pix", 32'(pix_idx), 32'(b + 1));
            else if (g < N_CH - 1) chk("stall_next_group", 32'({wload_req, dp_start, ch_idx}), 32'({2'b10, CW'(g + 1)}));
            else chk("stall_done", 32'(layer_done), 32'd1);
         end
      end
      chk("stall_gaps", 32'(stall_bad), 32'd0);
      cyc(0, 0, 0, 0);

      // Abort arriving with the final beat of the layer.
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (N_PIX) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      repeat (N_PIX - 1) cyc(0, 0, 0, 1);
      chk("pre_abort_pos", 32'({ch_idx, pix_idx}), 32'({CW'(N_CH - 1), CW'(N_PIX - 1)}));
      cyc(0, 1, 0, 1);
      chk("abort_final_beat", 32'(outs()), 32'h0);
      cyc(0, 0, 0, 0);
      chk("abort_no_done", 32'(outs()), 32'h0);

      // Asynchronous reset while wload_req is high, away from any clock edge.
      cyc(1, 0, 0, 0);
      chk("lw_req_high", 32'(wload_req), 32'd1);
      cfg_start = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst", 32'(outs()), 32'h0);
      chk("async_rst_min", 32'(outs_b()), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 0, 0, 0);
      chk("start_after_rst", 32'(outs()), 32'(pack(1, 0, 1, 0, 0, 0, 0)));

      // Degenerate sizing: one group, one beat.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 0, 0, 0);
      chk("min_load", 32'(outs_b()), 32'(pack(1, 0, 1, 0, 0, 0, 0)));
      cyc(0, 0, 1, 0);
      chk("min_run", 32'(outs_b()), 32'(pack(0, 1, 1, 0, 0, 0, 0)));
      cyc(0, 0, 0, 1);
      chk("min_done", 32'(outs_b()), 32'(pack(0, 0, 1, 1, 0, 0, 0)));
      cyc(0, 0, 0, 0);
      chk("min_idle", 32'(outs_b()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
